// File: rtl/decode_ctrl.sv
// decode_ctrl: two-stage sequencing controller around the combinational
// decode stage. Stage A holds the fetched instruction that drives decode.
// Stage B holds the registered uop offered to dispatch. Decoder-flagged
// NOPs are dropped, and invalid encodings raise a trap that is held until
// flush.
module decode_ctrl #(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned UOP_WIDTH   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   instr_valid_in,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic                   instr_ready_out,
  output logic [INSTR_WIDTH-1:0] dec_instr_out,
  input  logic                   dec_nop_in,
  input  logic                   dec_invalid_in,
  input  logic [UOP_WIDTH-1:0]   dec_uop_in,
  output logic                   uop_valid_out,
  output logic [UOP_WIDTH-1:0]   uop_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  input  logic                   uop_ready_in,
  output logic                   exc_valid_out,
  output logic [PC_WIDTH-1:0]    exc_pc_out,
  output logic [CNT_WIDTH-1:0]   issued_cnt_out,
  output logic [CNT_WIDTH-1:0]   nop_cnt_out
);

  typedef enum logic {S_RUN, S_EXC} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_a_valid;
  logic [INSTR_WIDTH-1:0] r_a_instr;
  logic [PC_WIDTH-1:0]    r_a_pc;

  logic                   r_b_valid;
  logic [UOP_WIDTH-1:0]   r_b_uop;
  logic [PC_WIDTH-1:0]    r_b_pc;

  logic                   r_exc_valid;
  logic [PC_WIDTH-1:0]    r_exc_pc;
  logic [CNT_WIDTH-1:0]   r_issued_cnt;
  logic [CNT_WIDTH-1:0]   r_nop_cnt;

  logic w_b_free;
  logic w_a_adv;
  logic w_a_load;
  logic w_retire_inv;
  logic w_retire_nop;
  logic w_b_load;
  logic w_issue;

  // Handshake and retire qualifiers
  always_comb begin
    w_b_free        = !r_b_valid || uop_ready_in;
    w_a_adv         = r_a_valid && w_b_free && (r_state == S_RUN);
    instr_ready_out = (r_state == S_RUN) && !flush && (!r_a_valid || w_a_adv);
    w_a_load        = instr_valid_in && instr_ready_out;
    w_retire_inv    = w_a_adv && dec_invalid_in;
    w_retire_nop    = w_a_adv && !dec_invalid_in && dec_nop_in;
    w_b_load        = w_a_adv && !dec_invalid_in && !dec_nop_in;
    w_issue         = r_b_valid && uop_ready_in;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: invalid retire traps, only flush returns to RUN
  always_comb begin
    w_state_nxt = r_state;
    if (flush)                                  w_state_nxt = S_RUN;
    else if (r_state == S_RUN && w_retire_inv)  w_state_nxt = S_EXC;
  end

  // Stage A: fetch register feeding decode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_instr <= '0;
      r_a_pc    <= '0;
    end else if (flush) begin
      r_a_valid <= 1'b0;
    end else if (w_a_load) begin
      r_a_valid <= 1'b1;
      r_a_instr <= instr_in;
      r_a_pc    <= pc_in;
    end else if (w_a_adv) begin
      r_a_valid <= 1'b0;
    end
  end

  // Stage B: registered uop toward dispatch, held stable while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      r_b_uop   <= '0;
      r_b_pc    <= '0;
    end else if (flush) begin
      r_b_valid <= 1'b0;
    end else if (w_b_load) begin
      r_b_valid <= 1'b1;
      r_b_uop   <= dec_uop_in;
      r_b_pc    <= r_a_pc;
    end else if (w_issue) begin
      r_b_valid <= 1'b0;
    end
  end

  // Exception hold: captured on invalid retire, cleared only by flush
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exc_valid <= 1'b0;
      r_exc_pc    <= '0;
    end else if (flush) begin
      r_exc_valid <= 1'b0;
    end else if (w_retire_inv) begin
      r_exc_valid <= 1'b1;
      r_exc_pc    <= r_a_pc;
    end
  end

  // Counters; a dispatch handshake in a flush cycle still counts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issued_cnt <= '0;
      r_nop_cnt    <= '0;
    end else begin
      if (w_issue)                r_issued_cnt <= r_issued_cnt + 1'b1;
      if (w_retire_nop && !flush) r_nop_cnt    <= r_nop_cnt + 1'b1;
    end
  end

  assign dec_instr_out  = r_a_instr;
  assign uop_valid_out  = r_b_valid;
  assign uop_out        = r_b_uop;
  assign pc_out         = r_b_pc;
  assign exc_valid_out  = r_exc_valid;
  assign exc_pc_out     = r_exc_pc;
  assign issued_cnt_out = r_issued_cnt;
  assign nop_cnt_out    = r_nop_cnt;

endmodule
